// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types, constants and width helpers for the bus fabric
//
// Contents:
//   bus_state_t      : transaction FSM states
//   DEFAULT_ERR_DATA : read data returned on unmapped/aborted accesses
//   slot_idx_w()     : width of a slot index for n slots
//   wdog_cnt_w()     : width of a watchdog counter able to hold the value t
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        ERR_RSP = 2'd3
    } bus_state_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'h6666_6666;

    function automatic int slot_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int wdog_cnt_w(input int t);
        return (t <= 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/bus_interconnect_if.sv
// rtl/bus_interconnect_if.sv - CPU-side and slot-side bus signals of the fabric
//
// Signals:
//   m_addr/m_rstrb/m_wmask   : CPU request (write data routed elsewhere)
//   m_rdata/m_rbusy/m_wbusy  : response to the CPU
//   s_rstrb/s_wmask          : per-slot strobes, slot k at bit k / [4k+3:4k]
//   s_rdata/s_rbusy/s_wbusy  : per-slot responses, slot k data at [32k+31:32k]
// Modports:
//   master : the environment (CPU plus slot targets) driving the fabric
//   slave  : the fabric itself
interface bus_interconnect_if #(
    parameter int NUM_SLAVES = 6
);
    logic [31:0]              m_addr;
    logic                     m_rstrb;
    logic [3:0]               m_wmask;
    logic [31:0]              m_rdata;
    logic                     m_rbusy;
    logic                     m_wbusy;
    logic [NUM_SLAVES-1:0]    s_rstrb;
    logic [4*NUM_SLAVES-1:0]  s_wmask;
    logic [32*NUM_SLAVES-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]    s_rbusy;
    logic [NUM_SLAVES-1:0]    s_wbusy;

    modport master (
        output m_addr, m_rstrb, m_wmask, s_rdata, s_rbusy, s_wbusy,
        input  m_rdata, m_rbusy, m_wbusy, s_rstrb, s_wmask
    );

    modport slave (
        input  m_addr, m_rstrb, m_wmask, s_rdata, s_rbusy, s_wbusy,
        output m_rdata, m_rbusy, m_wbusy, s_rstrb, s_wmask
    );

endinterface

// File: rtl/bus_page_decoder.sv
// rtl/bus_page_decoder.sv - combinational page decode of a CPU address into a slot
//
// Ports:
//   addr       in  32          CPU address
//   sel_onehot out NUM_SLAVES  one-hot selected slot, all zero when unmapped
//   sel_idx    out idx width   selected slot index (0 when unmapped)
//   unmapped   out 1           address lies in the I/O window but has no slot
module bus_page_decoder
    import bus_pkg::*;
#(
    parameter int          PAGE_SHIFT = 16,
    parameter int unsigned BASE_PAGE  = 'h0040,
    parameter int unsigned IO_PAGES   = 8,
    parameter int          NUM_SLAVES = 6
) (
    input  logic [31:0]                        addr,
    output logic [NUM_SLAVES-1:0]              sel_onehot,
    output logic [slot_idx_w(NUM_SLAVES)-1:0]  sel_idx,
    output logic                               unmapped
);
    localparam int IDX_W = slot_idx_w(NUM_SLAVES);

    // 33-bit arithmetic so the window bounds never wrap.
    localparam logic [32:0] WIN_LO   = 33'(BASE_PAGE);
    localparam logic [32:0] WIN_HI   = 33'(BASE_PAGE) + 33'(IO_PAGES);
    localparam logic [32:0] IO_SLOTS = 33'(NUM_SLAVES - 1);

    logic [32:0] page;
    logic [32:0] k;
    logic        in_window;

    always_comb begin
        page      = {1'b0, addr >> PAGE_SHIFT};
        k         = page - WIN_LO;
        in_window = (page >= WIN_LO) && (page < WIN_HI);
        unmapped  = in_window && (k >= IO_SLOTS);

        sel_idx = '0;
        if (in_window && !unmapped) begin
            sel_idx = IDX_W'(k + 33'd1);
        end

        sel_onehot = '0;
        if (!unmapped) begin
            sel_onehot[sel_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_interconnect.sv
// rtl/bus_interconnect.sv - single-master page-decoded bus fabric with watchdog and error log
//
// Ports:
//   clk       in  1   system clock
//   rst       in  1   synchronous active-high reset
//   bus       slave modport of bus_interconnect_if (CPU and per-slot signals)
//   err_valid out 1   sticky error flag
//   err_addr  out 32  address of the first uncleared error
//   err_clr   in  1   clears err_valid/err_addr (a coincident new error wins)
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int          NUM_SLAVES = 6,
    parameter int          PAGE_SHIFT = 16,
    parameter int unsigned BASE_PAGE  = 'h0040,
    parameter int unsigned IO_PAGES   = 8,
    parameter int unsigned TIMEOUT    = 16,
    parameter logic [31:0] ERR_DATA   = DEFAULT_ERR_DATA
) (
    input  logic                    clk,
    input  logic                    rst,
    bus_interconnect_if.slave       bus,
    output logic                    err_valid,
    output logic [31:0]             err_addr,
    input  logic                    err_clr
);
    localparam int IDX_W = slot_idx_w(NUM_SLAVES);
    localparam int CNT_W = wdog_cnt_w(int'(TIMEOUT));
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [NUM_SLAVES-1:0] sel_onehot;
    logic [IDX_W-1:0]      sel_idx;
    logic                  unmapped;

    bus_page_decoder #(
        .PAGE_SHIFT (PAGE_SHIFT),
        .BASE_PAGE  (BASE_PAGE),
        .IO_PAGES   (IO_PAGES),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_decoder (
        .addr       (bus.m_addr),
        .sel_onehot (sel_onehot),
        .sel_idx    (sel_idx),
        .unmapped   (unmapped)
    );

    bus_state_t            state;
    bus_state_t            state_nxt;
    logic [IDX_W-1:0]      sel_q;
    logic [31:0]           addr_q;
    logic [CNT_W-1:0]      wd_cnt;

    logic                  rd_req;
    logic                  wr_req;
    logic                  any_req;
    logic                  in_wait;
    logic                  slot_busy;
    logic                  abort;
    logic                  err_set;
    logic [31:0]           err_set_addr;
    logic [NUM_SLAVES-1:0] rstrb_vec;
    logic [4*NUM_SLAVES-1:0] wmask_vec;

    assign rd_req    = bus.m_rstrb;
    assign wr_req    = |bus.m_wmask;
    assign any_req   = rd_req | wr_req;
    assign in_wait   = (state == RD_WAIT) || (state == WR_WAIT);
    assign slot_busy = (state == RD_WAIT) ? bus.s_rbusy[sel_q] : bus.s_wbusy[sel_q];
    // The watchdog fires on the busy cycle after TIMEOUT busy cycles have been counted.
    assign abort     = (TIMEOUT != 0) && in_wait && slot_busy && (wd_cnt == CNT_MAX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a simultaneous read+write is treated as a write.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (unmapped)    state_nxt = ERR_RSP;
                    else if (wr_req) state_nxt = WR_WAIT;
                    else             state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: if (!bus.s_rbusy[sel_q] || abort) state_nxt = IDLE;
            WR_WAIT: if (!bus.s_wbusy[sel_q] || abort) state_nxt = IDLE;
            ERR_RSP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rstrb_vec   = '0;
        wmask_vec   = '0;
        bus.m_rbusy = 1'b0;
        bus.m_wbusy = 1'b0;
        bus.m_rdata = bus.s_rdata[32*int'(sel_q) +: 32];
        if (rst) begin
            bus.m_rdata = bus.s_rdata[31:0];
        end else begin
            case (state)
                IDLE: begin
                    if (!unmapped) begin
                        if (wr_req)      wmask_vec[4*int'(sel_idx) +: 4] = bus.m_wmask;
                        else if (rd_req) rstrb_vec = sel_onehot;
                    end
                end
                RD_WAIT: begin
                    bus.m_rbusy = bus.s_rbusy[sel_q] && !abort;
                    if (abort) bus.m_rdata = ERR_DATA;
                end
                WR_WAIT: begin
                    bus.m_wbusy = bus.s_wbusy[sel_q] && !abort;
                    if (abort) bus.m_rdata = ERR_DATA;
                end
                ERR_RSP: bus.m_rdata = ERR_DATA;
                default: ;
            endcase
        end
        bus.s_rstrb = rstrb_vec;
        bus.s_wmask = wmask_vec;
    end

    // Selected-slot latch and watchdog counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            addr_q <= '0;
            wd_cnt <= '0;
        end else if (state == IDLE && any_req && !unmapped) begin
            sel_q  <= sel_idx;
            addr_q <= bus.m_addr;
            wd_cnt <= '0;
        end else if (in_wait && slot_busy && wd_cnt != CNT_MAX) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    // Error sources: watchdog abort (reports the stalled address), unmapped or
    // colliding requests in IDLE, and any request arriving outside IDLE.
    always_comb begin
        err_set      = 1'b0;
        err_set_addr = bus.m_addr;
        if (abort) begin
            err_set      = 1'b1;
            err_set_addr = addr_q;
        end else if (state == IDLE) begin
            err_set = any_req && (unmapped || (rd_req && wr_req));
        end else begin
            err_set = any_req;
        end
    end

    // Sticky error register: first address kept until cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (err_set && (!err_valid || err_clr)) begin
            err_valid <= 1'b1;
            err_addr  <= err_set_addr;
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// tb/tb_bus_interconnect.sv - self-checking bench for bus_interconnect
module tb_bus_interconnect;

    localparam int          NS      = 6;
    localparam logic [31:0] ERR_VAL = 32'h6666_6666;

    logic        clk;
    logic        rst;
    logic        err_valid;
    logic [31:0] err_addr;
    logic        err_clr;

    bus_interconnect_if #(.NUM_SLAVES(NS)) bus ();

    bus_interconnect #(
        .NUM_SLAVES (NS),
        .PAGE_SHIFT (16),
        .BASE_PAGE  ('h0040),
        .IO_PAGES   (8),
        .TIMEOUT    (16),
        .ERR_DATA   (ERR_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] slot_data [NS];
    bit          exp_err_valid;
    logic [31:0] exp_err_addr;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [3:0]  mask;
        int          lat;
        int          exp_slot;   // -1 = unmapped
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode straight from the address map: pages 0x40..0x47 form the
    // I/O window, the first five of them back slots 1..5, the rest are holes.
    function automatic int ref_slot(input logic [31:0] a);
        int page;
        page = int'(a >> 16);
        if (page >= 'h40 && page < 'h48) return (page - 'h40 < NS - 1) ? page - 'h40 + 1 : -1;
        return 0;
    endfunction

    task automatic load_slots();
        for (int k = 0; k < NS; k++) bus.s_rdata[32*k +: 32] = slot_data[k];
    endtask

    task automatic model_err(input logic [31:0] a);
        if (!exp_err_valid) begin
            exp_err_valid = 1'b1;
            exp_err_addr  = a;
        end
    endtask

    task automatic chk_err(input string tag);
        chk({tag, "/err_valid"}, 64'(err_valid), 64'(exp_err_valid));
        chk({tag, "/err_addr"}, 64'(err_addr), 64'(exp_err_addr));
    endtask

    task automatic clear_err();
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_err_valid = 1'b0;
        exp_err_addr  = '0;
        @(negedge clk);
        chk_err("clear");
    endtask

    // One complete access with the addressed slot busy for lat cycles.
    task automatic access(input logic [31:0] a, input bit wr, input logic [3:0] mk,
                          input int lat, input int slot, input string tag);
        logic [NS-1:0]   exp_rstrb;
        logic [4*NS-1:0] exp_wmask;
        exp_rstrb = (!wr && slot >= 0) ? NS'(1 << slot) : '0;
        exp_wmask = (wr && slot >= 0) ? ((4*NS)'(mk) << (4*slot)) : '0;
        @(posedge clk); #1;
        bus.m_addr  = a;
        bus.m_rstrb = !wr;
        bus.m_wmask = wr ? mk : 4'h0;
        if (slot >= 0 && lat > 0) begin
            if (wr) bus.s_wbusy[slot] = 1'b1;
            else    bus.s_rbusy[slot] = 1'b1;
        end
        @(negedge clk);
        chk({tag, "/s_rstrb"}, 64'(bus.s_rstrb), 64'(exp_rstrb));
        chk({tag, "/s_wmask"}, 64'(bus.s_wmask), 64'(exp_wmask));
        @(posedge clk); #1;
        bus.m_rstrb = 1'b0;
        bus.m_wmask = 4'h0;
        if (slot < 0) model_err(a);
        if (slot >= 0) begin
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                chk({tag, "/busy_hi"}, 64'(wr ? bus.m_wbusy : bus.m_rbusy), 64'd1);
                @(posedge clk); #1;
                if (i == lat - 1) begin
                    bus.s_rbusy = '0;
                    bus.s_wbusy = '0;
                end
            end
        end
        @(negedge clk);
        chk({tag, "/busy_lo"}, 64'(bus.m_rbusy | bus.m_wbusy), 64'd0);
        if (!wr) chk({tag, "/rdata"}, 64'(bus.m_rdata), 64'(slot < 0 ? ERR_VAL : slot_data[slot]));
        chk_err(tag);
        @(posedge clk); #1;
    endtask

    int          n;
    logic [31:0] ra;
    int          rpage;
    bit          rwr;

    initial begin
        rst         = 1'b1;
        err_clr     = 1'b0;
        bus.m_addr  = '0;
        bus.m_rstrb = 1'b0;
        bus.m_wmask = 4'h0;
        bus.s_rbusy = '0;
        bus.s_wbusy = '0;
        for (int k = 0; k < NS; k++) slot_data[k] = 32'hA5A5_0000 | 32'(k);
        load_slots();
        exp_err_valid = 1'b0;
        exp_err_addr  = '0;

        tbl[0] = '{32'h0040_0004, 1'b0, 4'h0, 3,  1};
        tbl[1] = '{32'h0000_1000, 1'b1, 4'hF, 0,  0};
        tbl[2] = '{32'h0048_0000, 1'b1, 4'h3, 0,  0};
        tbl[3] = '{32'h0044_FFFC, 1'b0, 4'h0, 1,  5};
        tbl[4] = '{32'h0043_0000, 1'b1, 4'h5, 2,  4};
        tbl[5] = '{32'hFFFF_FFF0, 1'b0, 4'h0, 0,  0};
        tbl[6] = '{32'h003F_FFFC, 1'b0, 4'h0, 0,  0};
        tbl[7] = '{32'h0045_0000, 1'b0, 4'h0, 0, -1};
        tbl[8] = '{32'h0047_0000, 1'b0, 4'h0, 0, -1};
        tbl[9] = '{32'h0042_0010, 1'b1, 4'h8, 0,  3};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset/err_valid", 64'(err_valid), 64'd0);
        chk("reset/err_addr", 64'(err_addr), 64'd0);
        chk("reset/busy", 64'(bus.m_rbusy | bus.m_wbusy), 64'd0);
        chk("reset/s_rstrb", 64'(bus.s_rstrb), 64'd0);
        chk("reset/s_wmask", 64'(bus.s_wmask), 64'd0);
        chk("reset/rdata", 64'(bus.m_rdata), 64'(slot_data[0]));

        for (int i = 0; i < 10; i++)
            access(tbl[i].addr, tbl[i].wr, tbl[i].mask, tbl[i].lat, tbl[i].exp_slot,
                   $sformatf("vec%0d", i));

        // Watchdog: slot 2 never releases busy.
        clear_err();
        @(posedge clk); #1;
        bus.m_addr     = 32'h0041_0000;
        bus.m_rstrb    = 1'b1;
        bus.s_rbusy[2] = 1'b1;
        @(posedge clk); #1;
        bus.m_rstrb = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.m_rbusy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout/busy_cycles", 64'(n), 64'd16);
        chk("timeout/rdata", 64'(bus.m_rdata), 64'(ERR_VAL));
        @(posedge clk); #1;
        bus.s_rbusy[2] = 1'b0;
        model_err(32'h0041_0000);
        @(negedge clk);
        chk_err("timeout");
        access(32'h0000_0000, 1'b0, 4'h0, 0, 0, "after_timeout");

        // err_clr coincident with a new unmapped write: the new error wins.
        @(posedge clk); #1;
        err_clr     = 1'b1;
        bus.m_addr  = 32'h0046_0000;
        bus.m_wmask = 4'hF;
        @(negedge clk);
        chk("clr_new/s_wmask", 64'(bus.s_wmask), 64'd0);
        @(posedge clk); #1;
        err_clr     = 1'b0;
        bus.m_wmask = 4'h0;
        exp_err_valid = 1'b1;
        exp_err_addr  = 32'h0046_0000;
        @(negedge clk);
        chk_err("clr_new");
        chk("clr_new/rdata", 64'(bus.m_rdata), 64'(ERR_VAL));

        // Simultaneous read and write: write goes through, read dropped, error logged.
        clear_err();
        @(posedge clk); #1;
        bus.m_addr  = 32'h0000_2000;
        bus.m_rstrb = 1'b1;
        bus.m_wmask = 4'h6;
        @(negedge clk);
        chk("rdwr/s_rstrb", 64'(bus.s_rstrb), 64'd0);
        chk("rdwr/s_wmask", 64'(bus.s_wmask), 64'h6);
        @(posedge clk); #1;
        bus.m_rstrb = 1'b0;
        bus.m_wmask = 4'h0;
        model_err(32'h0000_2000);
        @(negedge clk);
        chk("rdwr/wbusy", 64'(bus.m_wbusy), 64'd0);
        chk_err("rdwr");

        // Strobe arriving while a read is still stalled.
        clear_err();
        @(posedge clk); #1;
        bus.m_addr     = 32'h0040_0000;
        bus.m_rstrb    = 1'b1;
        bus.s_rbusy[1] = 1'b1;
        @(posedge clk); #1;
        bus.m_addr  = 32'h0000_3000;
        @(negedge clk);
        chk("stray/s_rstrb", 64'(bus.s_rstrb), 64'd0);
        chk("stray/rbusy", 64'(bus.m_rbusy), 64'd1);
        @(posedge clk); #1;
        bus.m_rstrb    = 1'b0;
        bus.s_rbusy[1] = 1'b0;
        model_err(32'h0000_3000);
        @(negedge clk);
        chk_err("stray");
        chk("stray/rdata", 64'(bus.m_rdata), 64'(slot_data[1]));
        @(posedge clk); #1;

        // Reset in the middle of a stalled read.
        bus.m_addr     = 32'h0042_0000;
        bus.m_rstrb    = 1'b1;
        bus.s_rbusy[3] = 1'b1;
        @(posedge clk); #1;
        bus.m_rstrb = 1'b0;
        @(negedge clk);
        chk("rst_mid/rbusy_before", 64'(bus.m_rbusy), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err_valid = 1'b0;
        exp_err_addr  = '0;
        @(negedge clk);
        chk("rst_mid/rbusy_after", 64'(bus.m_rbusy), 64'd0);
        chk("rst_mid/rdata", 64'(bus.m_rdata), 64'(slot_data[0]));
        chk_err("rst_mid");
        bus.s_rbusy[3] = 1'b0;
        access(32'h0000_0000, 1'b0, 4'h0, 0, 0, "rst_mid_next");

        // Randomised accesses checked against the reference decode and error model.
        for (int it = 0; it < 60; it++) begin
            for (int k = 0; k < NS; k++) slot_data[k] = $urandom;
            load_slots();
            if ($urandom_range(0, 3) == 0) clear_err();
            case ($urandom_range(0, 2))
                0:       rpage = int'($urandom_range(0, 'h3F));
                1:       rpage = 'h40 + int'($urandom_range(0, 7));
                default: rpage = int'($urandom_range(0, 'hFFFF));
            endcase
            ra  = (32'(rpage) << 16) | ($urandom & 32'h0000_FFFC);
            rwr = $urandom_range(0, 1) == 1;
            access(ra, rwr, 4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                   ref_slot(ra), $sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
